// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserialises {cmd, byte} command words from MOSI and returns RAM read data on MISO.
// Optional feature: define SPI_TX_TIMEOUT_EN to bound the read-data wait and raise a sticky tx_err.
module spi_slave_if #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned TX_W       = 8,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [TX_W-1:0]   tx_data,
    input  logic              tx_valid,
    output logic              tx_err
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned TXC_W = $clog2(TX_W);

    if (TX_TIMEOUT == 0) begin : g_bad_timeout
        $error("spi_slave_if: TX_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    // Progress inside a data frame: receive, wait for RAM, shift out, hold for SS_n.
    typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_SHIFT, PH_HOLD} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_seen_q, rd_seen_d;
    logic [TX_W-1:0]    out_q, out_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               miso_q, miso_d;
    logic [DATA_W-1:0]  in_word;

`ifdef SPI_TX_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TX_TIMEOUT + 1);
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               tx_err_q, tx_err_d;
`endif

    assign in_word = {shift_q[DATA_W-2:0], MOSI};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_seen_d  = rd_seen_q;
        out_d      = out_q;
        tx_cnt_d   = tx_cnt_q;
        miso_d     = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        tx_err_d   = tx_err_q;
`endif
        if (SS_n) begin
            state_d   = IDLE;
            phase_d   = PH_RX;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = CHK_CMD;
                CHK_CMD: begin
                    phase_d   = PH_RX;
                    bit_cnt_d = CNT_W'(DATA_W - 1);
                    if (!MOSI)          state_d = WRITE;
                    else if (rd_seen_q) state_d = READ_DATA;
                    else                state_d = READ_ADD;
                end
                default: begin
                    case (phase_q)
                        PH_RX: begin
                            shift_d = in_word;
                            if (bit_cnt_q == '0) begin
                                rx_data_d  = in_word;
                                rx_valid_d = 1'b1;
                                if (state_q == READ_ADD) rd_seen_d = 1'b1;
                                phase_d = (state_q == READ_DATA) ? PH_WAIT : PH_HOLD;
`ifdef SPI_TX_TIMEOUT_EN
                                wait_cnt_d = '0;
`endif
                            end else begin
                                bit_cnt_d = bit_cnt_q - CNT_W'(1);
                            end
                        end
                        PH_WAIT: begin
                            if (tx_valid) begin
                                miso_d   = tx_data[TX_W-1];
                                out_d    = {tx_data[TX_W-2:0], 1'b0};
                                tx_cnt_d = TXC_W'(TX_W - 1);
                                phase_d  = PH_SHIFT;
                            end
`ifdef SPI_TX_TIMEOUT_EN
                            // A timed-out read still spends TX_W cycles, shifting zeros.
                            else if (wait_cnt_q == WAIT_W'(TX_TIMEOUT - 1)) begin
                                tx_err_d = 1'b1;
                                out_d    = '0;
                                tx_cnt_d = TXC_W'(TX_W - 1);
                                phase_d  = PH_SHIFT;
                            end else begin
                                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                            end
`endif
                        end
                        PH_SHIFT: begin
                            if (tx_cnt_q != '0) begin
                                miso_d   = out_q[TX_W-1];
                                out_d    = {out_q[TX_W-2:0], 1'b0};
                                tx_cnt_d = tx_cnt_q - TXC_W'(1);
                            end else begin
                                rd_seen_d = 1'b0;
                                phase_d   = PH_HOLD;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= PH_RX;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            out_q      <= '0;
            tx_cnt_q   <= '0;
            miso_q     <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
            wait_cnt_q <= '0;
            tx_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_seen_q  <= rd_seen_d;
            out_q      <= out_d;
            tx_cnt_q   <= tx_cnt_d;
            miso_q     <= miso_d;
`ifdef SPI_TX_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            tx_err_q   <= tx_err_d;
`endif
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_TX_TIMEOUT_EN
    assign tx_err   = tx_err_q;
`else
    assign tx_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised frame-level bench for spi_slave_if; the model tracks only the read phase and sticky error.
module tb_spi_slave_if;
    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        m_rd_seen = 1'b0;
    logic        m_err     = 1'b0;

    spi_slave_if #(.DATA_W(10), .TX_W(8), .TX_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_valid, input logic exp_miso);
        check({tag, "_rxv"},  32'(rx_valid), 32'(exp_valid));
        check({tag, "_miso"}, 32'(MISO),     32'(exp_miso));
        check({tag, "_err"},  32'(tx_err),   32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // nbits < 10 aborts the frame after that many data bits; delay < 0 withholds tx_valid;
    // rst_at >= 0 asserts reset between clocks while MISO shows that bit index.
    task automatic frame(input logic cmd, input logic [9:0] word, input int nbits,
                         input logic [7:0] rbyte, input int delay, input int rst_at);
        logic rd_data;
        rd_data  = cmd && m_rd_seen;
        SS_n     = 1'b0;
        MOSI     = 1'($urandom);
        tx_valid = 1'($urandom);
        tx_data  = 8'($urandom);
        step();
        chk_out("start", 1'b0, 1'b0);
        MOSI = cmd;
        step();
        chk_out("cmd", 1'b0, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            if (nbits == 9 - i) begin
                SS_n = 1'b1;
                MOSI = 1'($urandom);
                step();
                chk_out("abort", 1'b0, 1'b0);
                return;
            end
            MOSI     = word[i];
            tx_valid = 1'($urandom);
            step();
            chk_out("bit", (i == 0), 1'b0);
            if (i == 0) check("rx_data", 32'(rx_data), 32'(word));
        end
        if (cmd && !m_rd_seen) begin
            m_rd_seen = 1'b1;
        end else if (rd_data) begin
            tx_valid = 1'b0;
            if (delay < 0) begin
                for (int k = 1; k <= 24; k++) begin
                    step();
                    if (k == 16) m_err = 1'b1;
                    chk_out("tmo", 1'b0, 1'b0);
                end
                m_rd_seen = 1'b0;
            end else begin
                repeat (delay) begin
                    step();
                    chk_out("wait", 1'b0, 1'b0);
                end
                tx_valid = 1'b1;
                tx_data  = rbyte;
                step();
                for (int b = 7; b >= 0; b--) begin
                    if (b == rst_at) begin
                        #2 rst = 1'b1;
                        #1;
                        m_err = 1'b0;
                        chk_out("rst_mid", 1'b0, 1'b0);
                        m_rd_seen = 1'b0;
                        SS_n      = 1'b1;
                        tx_valid  = 1'b0;
                        @(negedge clk);
                        rst = 1'b0;
                        step();
                        chk_out("rst_after", 1'b0, 1'b0);
                        return;
                    end
                    chk_out("shift", 1'b0, rbyte[b]);
                    tx_valid = 1'($urandom);
                    tx_data  = 8'($urandom);
                    step();
                end
                chk_out("shift_end", 1'b0, 1'b0);
                m_rd_seen = 1'b0;
            end
        end
        // Trailing cycles with SS_n still low: extra MOSI bits and stray tx_valid are ignored.
        repeat (3) begin
            MOSI     = 1'($urandom);
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            step();
            chk_out("hold", 1'b0, 1'b0);
        end
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        step();
        chk_out("end", 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        #12;
        chk_out("reset", 1'b0, 1'b0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        frame(1'b0, 10'h03A, 10, 8'h00, 0, -1);
        frame(1'b1, 10'h23A, 10, 8'h00, 0, -1);
        frame(1'b0, 10'h1A5, 10, 8'h00, 0, -1);
        frame(1'b1, 10'h3C7, 10, 8'hA5, 3, -1);
        frame(1'b1, 10'h2F0, 10, 8'h00, 0, 0);
        frame(1'b1, 10'h3FF, 10, 8'hFF, 0, -1);
        frame(1'b0, 10'h155,  5, 8'h00, 0, -1);
        frame(1'b0, 10'h155, 10, 8'h00, 0, -1);
        frame(1'b0, 10'h2AA,  9, 8'h00, 0, -1);
        frame(1'b0, 10'h0C3, 10, 8'h00, 0, -1);

        frame(1'b1, 10'h211, 10, 8'h00, 0, -1);
        frame(1'b1, 10'h322, 10, 8'h5A, 2, 4);
        frame(1'b1, 10'h233, 10, 8'h00, 0, -1);
        frame(1'b1, 10'h344, 10, 8'h81, 0, -1);

`ifdef SPI_TX_TIMEOUT_EN
        frame(1'b1, 10'h255, 10, 8'h00, 0, -1);
        frame(1'b1, 10'h366, 10, 8'h00, -1, -1);
        frame(1'b1, 10'h277, 10, 8'h00, 0, -1);
        frame(1'b1, 10'h388, 10, 8'h3C, 15, -1);
`endif

        for (int n = 0; n < 150; n++) begin
            frame(1'($urandom), 10'($urandom),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10,
                  8'($urandom), int'($urandom_range(0, 10)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
